// File: rtl/reg_read_pkg.sv
// Shared widths and buffer entry layout for the register read port.
package reg_read_pkg;

    localparam int REG_COUNT = 16;
    localparam int REG_W     = 8;
    localparam int IDX_W     = 4;
    localparam int TAG_W     = 4;

    localparam logic [IDX_W-1:0] MULT_HIGH_IDX = 4'd10;

    typedef struct packed {
        logic [REG_W-1:0] a;
        logic [REG_W-1:0] b;
        logic [IDX_W-1:0] sa;
        logic [IDX_W-1:0] sb;
        logic [TAG_W-1:0] tag;
        logic             stale;
    } rr_entry_t;

    typedef struct packed {
        logic [REG_W-1:0] a;
        logic [REG_W-1:0] b;
        logic [TAG_W-1:0] tag;
        logic             stale;
    } rr_rsp_t;

endpackage

// File: rtl/rr_entry_fifo.sv
// In-order response buffer with sticky per-entry stale bits.
module rr_entry_fifo
    import reg_read_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  rr_entry_t                   i_push_data,
    input  logic                        i_pop,
    input  logic [DEPTH-1:0]            i_stale_set,
    output logic [DEPTH-1:0][IDX_W-1:0] o_sa,
    output logic [DEPTH-1:0][IDX_W-1:0] o_sb,
    output logic                        o_full,
    output logic                        o_valid,
    output rr_rsp_t                     o_rsp
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rr_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]         r_wr;
    logic [PW-1:0]         r_rd;
    logic [CW-1:0]         r_cnt;

    logic      w_push;
    logic      w_pop;
    rr_entry_t w_head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_valid = (r_cnt != '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && o_valid;
    assign w_head  = r_mem[r_rd];

    always_comb begin
        o_rsp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_sa[i] = r_mem[i].sa;
            o_sb[i] = r_mem[i].sb;
        end
        if (o_valid) begin
            o_rsp.a     = w_head.a;
            o_rsp.b     = w_head.b;
            o_rsp.tag   = w_head.tag;
            o_rsp.stale = w_head.stale;
        end
    end

    // A push overrides any stale set aimed at the slot it refills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_stale_set[i]) r_mem[i].stale <= 1'b1;
            end
            if (w_push) begin
                r_mem[r_wr] <= i_push_data;
                r_wr        <= nxt(r_wr);
            end
            if (w_pop) r_rd <= nxt(r_rd);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/reg_read_port.sv
// Register operand read port: same-edge write bypass, buffered responses.
module reg_read_port
    import reg_read_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [IDX_W-1:0]                req_sa,
    input  logic [IDX_W-1:0]                req_sb,
    input  logic [TAG_W-1:0]                req_tag,
    input  logic [REG_COUNT-1:0][REG_W-1:0] rf_q,
    input  logic [REG_COUNT-1:0]            rf_en_n,
    input  logic [REG_W-1:0]                rf_d,
    input  logic [REG_W-1:0]                rf_mult_high,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [REG_W-1:0]                rsp_a,
    output logic [REG_W-1:0]                rsp_b,
    output logic [TAG_W-1:0]                rsp_tag,
    output logic                            rsp_stale
);

    logic                        w_full;
    logic                        w_push;
    logic                        w_pop;
    rr_entry_t                   w_cap;
    rr_rsp_t                     w_rsp;
    logic [DEPTH-1:0]            w_stale_set;
    logic [DEPTH-1:0][IDX_W-1:0] w_sa;
    logic [DEPTH-1:0][IDX_W-1:0] w_sb;

    // Operand as it will read after this edge's register file write.
    function automatic logic [REG_W-1:0] operand(input logic [IDX_W-1:0] idx);
        if (rf_en_n[idx]) return rf_q[idx];
        return (idx == MULT_HIGH_IDX) ? rf_mult_high : rf_d;
    endfunction

    assign req_ready = rst_n && !w_full;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = rsp_valid && rsp_ready;

    always_comb begin
        w_cap       = '0;
        w_cap.a     = operand(req_sa);
        w_cap.b     = operand(req_sb);
        w_cap.sa    = req_sa;
        w_cap.sb    = req_sb;
        w_cap.tag   = req_tag;
        w_stale_set = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_stale_set[i] = !rf_en_n[w_sa[i]] || !rf_en_n[w_sb[i]];
        end
    end

    rr_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_cap),
        .i_pop       (w_pop),
        .i_stale_set (w_stale_set),
        .o_sa        (w_sa),
        .o_sb        (w_sb),
        .o_full      (w_full),
        .o_valid     (rsp_valid),
        .o_rsp       (w_rsp)
    );

    assign rsp_a     = w_rsp.a;
    assign rsp_b     = w_rsp.b;
    assign rsp_tag   = w_rsp.tag;
    assign rsp_stale = w_rsp.stale;

endmodule

// File: tb/tb_reg_read_port.sv
// Randomized bench for reg_read_port against a queue-based reference model.
module tb_reg_read_port;

    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_sa;
    logic [3:0]       req_sb;
    logic [3:0]       req_tag;
    logic [15:0][7:0] rf_q;
    logic [15:0]      rf_en_n;
    logic [7:0]       rf_d;
    logic [7:0]       rf_mult_high;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_a;
    logic [7:0]       rsp_b;
    logic [3:0]       rsp_tag;
    logic             rsp_stale;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] tag;
        logic       stale;
    } m_t;

    m_t q[$];
    m_t m_new;
    int m_n;
    bit m_acc;
    bit m_pop;

    reg_read_port #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sa       (req_sa),
        .req_sb       (req_sb),
        .req_tag      (req_tag),
        .rf_q         (rf_q),
        .rf_en_n      (rf_en_n),
        .rf_d         (rf_d),
        .rf_mult_high (rf_mult_high),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_a        (rsp_a),
        .rsp_b        (rsp_b),
        .rsp_tag      (rsp_tag),
        .rsp_stale    (rsp_stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd(input logic [3:0] idx);
        if (rf_en_n[idx]) return rf_q[idx];
        return (idx == 4'd10) ? rf_mult_high : rf_d;
    endfunction

    always @(negedge rst_n) q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            m_n   = q.size();
            m_acc = req_valid && (m_n < DEPTH);
            m_pop = (m_n > 0) && rsp_ready;
            foreach (q[i]) begin
                if (!rf_en_n[q[i].sa] || !rf_en_n[q[i].sb]) q[i].stale = 1'b1;
            end
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                m_new.a     = rd(req_sa);
                m_new.b     = rd(req_sb);
                m_new.sa    = req_sa;
                m_new.sb    = req_sb;
                m_new.tag   = req_tag;
                m_new.stale = 1'b0;
                q.push_back(m_new);
            end
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(rst_n && (q.size() < DEPTH)));
        check("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("rsp_a", 32'(rsp_a), 32'(q[0].a));
            check("rsp_b", 32'(rsp_b), 32'(q[0].b));
            check("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
            check("rsp_stale", 32'(rsp_stale), 32'(q[0].stale));
        end else begin
            check("idle_fields", {15'd0, rsp_stale, rsp_tag, rsp_b, rsp_a}, 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] tag);
        req_valid = 1'b1;
        req_sa    = sa;
        req_sb    = sb;
        req_tag   = tag;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_sa       = '0;
        req_sb       = '0;
        req_tag      = '0;
        rf_q         = '0;
        rf_en_n      = '1;
        rf_d         = '0;
        rf_mult_high = '0;
        rsp_ready    = 1'b0;
        cyc();
        cyc();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        cyc();
        check("rel_ready", 32'(req_ready), 32'd1);

        rf_q[3] = 8'h5A;
        rf_q[7] = 8'hC3;
        rsp_ready = 1'b1;
        req(4'd3, 4'd7, 4'd1);
        cyc();
        req_valid = 1'b0;
        check("t33_valid", 32'(rsp_valid), 32'd1);
        check("t33_a", 32'(rsp_a), 32'h5A);
        check("t33_b", 32'(rsp_b), 32'hC3);
        check("t33_tag", 32'(rsp_tag), 32'd1);
        check("t33_stale", 32'(rsp_stale), 32'd0);
        cyc();
        check("t33_drain", 32'(rsp_valid), 32'd0);

        rf_q[10] = 8'h00;
        rf_en_n[10] = 1'b0;
        rf_mult_high = 8'h99;
        rf_d = 8'h11;
        req(4'd10, 4'd10, 4'd2);
        cyc();
        req_valid = 1'b0;
        rf_en_n = '1;
        check("t34_a", 32'(rsp_a), 32'h99);
        check("t34_b", 32'(rsp_b), 32'h99);
        check("t34_stale", 32'(rsp_stale), 32'd0);
        cyc();

        rsp_ready = 1'b0;
        req(4'd1, 4'd2, 4'd1);
        cyc();
        check("t35_ready1", 32'(req_ready), 32'd1);
        req(4'd3, 4'd4, 4'd2);
        cyc();
        check("t35_full", 32'(req_ready), 32'd0);
        req(4'd5, 4'd6, 4'd3);
        cyc();
        check("t35_hold", 32'(rsp_tag), 32'd1);
        rsp_ready = 1'b1;
        cyc();
        check("t35_tag2", 32'(rsp_tag), 32'd2);
        cyc();
        req_valid = 1'b0;
        check("t37_ready", 32'(req_ready), 32'd1);
        check("t35_tag3", 32'(rsp_tag), 32'd3);
        cyc();
        check("t35_empty", 32'(rsp_valid), 32'd0);

        rsp_ready = 1'b0;
        req(4'd2, 4'd5, 4'd4);
        cyc();
        req(4'd6, 4'd6, 4'd5);
        rf_en_n[2] = 1'b0;
        cyc();
        req_valid = 1'b0;
        rf_en_n = '1;
        check("t36_tag", 32'(rsp_tag), 32'd4);
        check("t36_stale", 32'(rsp_stale), 32'd1);
        rsp_ready = 1'b1;
        cyc();
        check("t36_tag5", 32'(rsp_tag), 32'd5);
        check("t36_clean", 32'(rsp_stale), 32'd0);
        cyc();

        rsp_ready = 1'b0;
        req(4'd8, 4'd9, 4'd6);
        cyc();
        req(4'd9, 4'd8, 4'd7);
        cyc();
        req_valid = 1'b0;
        check("t38_full", 32'(req_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1 check("t38_valid", 32'(rsp_valid), 32'd0);
        cyc();
        rst_n = 1'b1;
        #1 check("t38_ready", 32'(req_ready), 32'd1);
        check("t38_drop", 32'(rsp_valid), 32'd0);
        cyc();

        for (int i = 0; i < 3000; i++) begin
            req_valid    = ($urandom_range(0, 3) != 0);
            req_sa       = 4'($urandom_range(0, 15));
            req_sb       = ($urandom_range(0, 3) == 0) ? req_sa : 4'($urandom_range(0, 15));
            req_tag      = 4'($urandom_range(0, 15));
            rsp_ready    = ($urandom_range(0, 2) != 0);
            rf_d         = 8'($urandom);
            rf_mult_high = 8'($urandom);
            rf_q[$urandom_range(0, 15)] = 8'($urandom);
            rf_en_n = '1;
            if ($urandom_range(0, 2) == 0) rf_en_n[$urandom_range(0, 15)] = 1'b0;
            if ($urandom_range(0, 9) == 0) rf_en_n[10] = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        req_valid = 1'b0;
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 Parameter DEPTH, default 2: response buffer entries; legal range 2..4.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  read request present.
REQ-005 req_ready  output  1  request accepted this edge when req_valid && req_ready.
REQ-006 req_sa  input  4  source register index A.
REQ-007 req_sb  input  4  source register index B.
REQ-008 req_tag  input  4  opaque tag returned with response.
REQ-009 rf_q  input  16x8  current register file contents, index 0..15.
REQ-010 rf_en_n  input  16  register file write enables, active-low, one per register.
REQ-011 rf_d  input  8  register file write data for indices other than 10.
REQ-012 rf_mult_high  input  8  register file write data for index 10.
REQ-013 rsp_valid  output  1  response at buffer head.
REQ-014 rsp_ready  input  1  consumer takes head when rsp_valid && rsp_ready.
REQ-015 rsp_a, rsp_b  output  8 each  operand snapshots for req_sa, req_sb.
REQ-016 rsp_tag  output  4  tag of head entry.
REQ-017 rsp_stale  output  1  head entry's source A or B was written after capture.

Function
REQ-018 Accept = req_valid && req_ready; pop = rsp_valid && rsp_ready.
REQ-019 req_ready SHALL be 1 iff occupancy < DEPTH (registered count; no combinational path from rsp_ready).
REQ-020 On accept, operand X SHALL be captured as: rf_d if rf_en_n[idx]==0 and idx!=10; rf_mult_high if rf_en_n[10]==0 and idx==10; else rf_q[idx] (same-edge write bypass).
REQ-021 req_sa == req_sb SHALL yield identical rsp_a and rsp_b.
REQ-022 Latency: request accepted at edge N into empty buffer SHALL present rsp_valid=1 after edge N; no same-cycle pass-through.
REQ-023 Responses SHALL leave in acceptance order (FIFO); pointers wrap modulo DEPTH.
REQ-024 Simultaneous accept and pop SHALL leave occupancy unchanged; at DEPTH full, req_ready=0 so no accept occurs.
REQ-025 Each buffered entry SHALL hold a stale bit, cleared at capture, set on any later edge where rf_en_n[sa]==0 or rf_en_n[sb]==0 while the entry is buffered.
REQ-026 Writes on the capture edge SHALL NOT set stale (covered by bypass); stale is sticky until pop.
REQ-027 rsp_a/rsp_b/rsp_tag/rsp_stale SHALL be 0 when rsp_valid=0.
REQ-028 Pop with rsp_valid=0 SHALL be ignored; no underflow.

Reset
REQ-029 rst_n low SHALL immediately clear occupancy, pointers, stale bits and all outputs to 0; req_ready=1 on first edge after deassert.
REQ-030 Reset mid-operation SHALL discard all buffered responses; no partial response emitted.

Structure
REQ-031 Package reg_read_pkg SHALL hold REG_COUNT=16, REG_W=8, IDX_W=4, TAG_W=4, MULT_HIGH_IDX=10 and packed struct rr_entry_t {a, b, sa, sb, tag, stale}.
REQ-032 Buffer SHALL be sub-module rr_entry_fifo (parameterized DEPTH, rr_entry_t payload, per-entry stale update port); bypass/capture logic in top.

Verification
REQ-033 Reset, rf_q[3]=8'h5A, rf_q[7]=8'hC3, request sa=3 sb=7 tag=1, rsp_ready=1 -> next cycle rsp_a=5A rsp_b=C3 tag=1 stale=0.
REQ-034 Request sa=10 with rf_en_n[10]=0, rf_mult_high=8'h99, rf_q[10]=8'h00 same edge -> rsp_a=99, stale=0.
REQ-035 rsp_ready=0, three back-to-back requests, DEPTH=2 -> req_ready=0 after second accept; release rsp_ready -> tags returned 1,2,3 in order.
REQ-036 Buffer request sa=2, next edge rf_en_n[2]=0 while held -> rsp_stale=1 at pop; next entry stale=0.
REQ-037 Occupancy 1, accept and pop same edge -> occupancy stays 1, head advances.
REQ-038 Buffer full, assert rst_n=0 mid-cycle -> rsp_valid=0 immediately, req_ready=1 after release.
